// File: rtl/penta_root_dispatch.sv
// ---------------------------------------------------------------------------
// penta_root_dispatch
//
// Sits in front of and behind the N-slot MinRoot 5th-root engine. Tagged
// operands arrive on one valid/ready stream. Each operand is started on the
// lowest-index free engine slot with a one-cycle pulse. Results are captured
// on the slot's done pulse and leave through a small result FIFO. The FIFO is
// credit-protected: a job is only accepted when the FIFO is guaranteed to
// have room for its result, so the engine is never stalled.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  operand handshake (ready does not look at valid)
//   in_x_i, in_tag_i       operand and its tag
//   out_valid_o/out_ready_i result handshake (FIFO head, registered)
//   out_x_o, out_tag_o     head result and its tag
//   eng_start_o            per-slot start pulse, at most one bit set
//   eng_x_o                per-slot operand (all slots carry in_x_i)
//   eng_x_i, eng_done_i    per-slot result and done pulse from the engine
//   eng_sync_i             engine sync; gates starts when SYNC=1
//   outstanding_o          number of busy slots
//   err_o                  sticky protocol error
// ---------------------------------------------------------------------------
module penta_root_dispatch #(
    parameter int N         = 1,
    parameter int SYNC      = 0,
    parameter int TAG_W     = 8,
    parameter int OUT_DEPTH = 4,
    parameter int X_W       = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [X_W-1:0]         in_x_i,
    input  logic [TAG_W-1:0]       in_tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [X_W-1:0]         out_x_o,
    output logic [TAG_W-1:0]       out_tag_o,
    output logic [N-1:0]           eng_start_o,
    output logic [N-1:0][X_W-1:0]  eng_x_o,
    input  logic [N-1:0][X_W-1:0]  eng_x_i,
    input  logic [N-1:0]           eng_done_i,
    input  logic                   eng_sync_i,
    output logic [$clog2(N+1)-1:0] outstanding_o,
    output logic                   err_o
);

    localparam int OCNT_W = $clog2(N + 1);
    localparam int SEL_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);

    // Slot tracking
    logic [N-1:0]             r_busy;
    logic [N-1:0][TAG_W-1:0]  r_tag;

    // Result FIFO
    logic [X_W-1:0]           r_mem_x   [OUT_DEPTH];
    logic [TAG_W-1:0]         r_mem_tag [OUT_DEPTH];
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [CNT_W-1:0]         r_count;

    logic                     r_err;

    logic [N-1:0]             w_free;
    logic [N-1:0]             w_start;
    logic                     w_any_free;
    logic [SEL_W-1:0]         w_sel;
    logic [OCNT_W-1:0]        w_outstanding;
    logic [OCNT_W-1:0]        w_done_cnt;
    logic                     w_done_any;
    logic [SEL_W-1:0]         w_done_idx;
    logic                     w_multi_done;
    logic                     w_idle_done;
    logic                     w_credit_ok;
    logic                     w_sync_ok;
    logic                     w_ready;
    logic                     w_fire;
    logic                     w_full;
    logic                     w_push;
    logic                     w_push_ok;
    logic                     w_pop;
    logic [PTR_W-1:0]         w_wptr_nxt;
    logic [PTR_W-1:0]         w_rptr_nxt;

    // -----------------------------------------------------------------------
    // Slot scan: a slot finishing this cycle counts as free so it can be
    // restarted in its own done cycle. The downward loop leaves the lowest
    // index in w_sel / w_done_idx.
    // -----------------------------------------------------------------------
    always_comb begin
        w_free        = ~r_busy | eng_done_i;
        w_any_free    = 1'b0;
        w_sel         = '0;
        w_done_any    = 1'b0;
        w_done_idx    = '0;
        w_outstanding = '0;
        w_done_cnt    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_free[k]) begin
                w_any_free = 1'b1;
                w_sel      = SEL_W'(k);
            end
            if (eng_done_i[k]) begin
                w_done_any = 1'b1;
                w_done_idx = SEL_W'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            w_outstanding = w_outstanding + OCNT_W'(r_busy[k]);
            w_done_cnt    = w_done_cnt + OCNT_W'(eng_done_i[k]);
        end
    end

    // A done moves a job from outstanding into the FIFO, leaving the sum
    // unchanged, and a pop only frees credit once r_count has dropped, so
    // the sum of registered values is exactly the reserved result space.
    assign w_credit_ok = (32'(w_outstanding) + 32'(r_count)) < 32'(OUT_DEPTH);
    assign w_sync_ok   = (SYNC == 0) || eng_sync_i;
    assign w_ready     = w_any_free & w_credit_ok & w_sync_ok;
    assign w_fire      = in_valid_i & w_ready;
    assign w_start     = w_fire ? (N'(1) << w_sel) : '0;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            eng_x_o[k] = in_x_i;
        end
    end

    // Protocol checks feeding the sticky error
    assign w_multi_done = (w_done_cnt > OCNT_W'(1));
    assign w_idle_done  = |(eng_done_i & ~r_busy);

    // -----------------------------------------------------------------------
    // FIFO control. Fullness is judged on the registered count, so a push
    // into a full FIFO is dropped and flagged even if a pop happens too.
    // -----------------------------------------------------------------------
    assign w_full     = (r_count == CNT_W'(OUT_DEPTH));
    assign w_push     = w_done_any;
    assign w_push_ok  = w_push & ~w_full;
    assign w_pop      = (r_count != '0) & out_ready_i;
    assign w_wptr_nxt = (r_wptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_rptr + 1'b1;

    // FIFO storage needs no reset; only entries below r_count are ever read.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem_x[r_wptr]   <= eng_x_i[w_done_idx];
            r_mem_tag[r_wptr] <= r_tag[w_done_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy  <= '0;
            r_tag   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            // A restart in the done cycle wins over the clear.
            for (int k = 0; k < N; k++) begin
                if (w_start[k]) begin
                    r_busy[k] <= 1'b1;
                    r_tag[k]  <= in_tag_i;
                end else if (eng_done_i[k]) begin
                    r_busy[k] <= 1'b0;
                end
            end

            if (w_push_ok) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_multi_done || w_idle_done || (w_push && w_full)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready_o    = w_ready;
    assign eng_start_o   = w_start;
    assign out_valid_o   = (r_count != '0);
    assign out_x_o       = r_mem_x[r_rptr];
    assign out_tag_o     = r_mem_tag[r_rptr];
    assign outstanding_o = w_outstanding;
    assign err_o         = r_err;

endmodule

// File: tb/tb_penta_root_dispatch.sv
// ---------------------------------------------------------------------------
// Bench for penta_root_dispatch. A main instance (N=4, SYNC=0, OUT_DEPTH=8)
// is driven by a behavioural engine with 258-cycle latency and checked every
// cycle against a job-level model (in-flight job queue, result queue, per-slot
// release times). A second instance (N=3, SYNC=1) checks sync-gated issue.
// ---------------------------------------------------------------------------
module tb_penta_root_dispatch;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int TW    = 8;
    localparam int XW    = 32;
    localparam int LAT   = 258;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [XW-1:0]        in_x;
    logic [TW-1:0]        in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XW-1:0]        out_x;
    logic [TW-1:0]        out_tag;
    logic [N-1:0]         eng_start;
    logic [N-1:0][XW-1:0] eng_xo;
    logic [N-1:0][XW-1:0] eng_xi;
    logic [N-1:0]         eng_done;
    logic                 eng_sync;
    logic [2:0]           outstanding;
    logic                 err;

    penta_root_dispatch #(.N(N), .SYNC(0), .TAG_W(TW), .OUT_DEPTH(DEPTH), .X_W(XW)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_x_o(out_x), .out_tag_o(out_tag),
        .eng_start_o(eng_start), .eng_x_o(eng_xo), .eng_x_i(eng_xi), .eng_done_i(eng_done),
        .eng_sync_i(eng_sync), .outstanding_o(outstanding), .err_o(err)
    );

    // Sync-mode instance; its engine never completes.
    logic                 s_in_valid;
    logic                 s_in_ready;
    logic [XW-1:0]        s_in_x;
    logic [TW-1:0]        s_in_tag;
    logic                 s_out_valid;
    logic                 s_out_ready;
    logic [XW-1:0]        s_out_x;
    logic [TW-1:0]        s_out_tag;
    logic [2:0]           s_start;
    logic [2:0][XW-1:0]   s_eng_xo;
    logic [2:0][XW-1:0]   s_eng_xi;
    logic [2:0]           s_done;
    logic                 s_sync;
    logic [1:0]           s_outst;
    logic                 s_err;

    penta_root_dispatch #(.N(3), .SYNC(1), .TAG_W(TW), .OUT_DEPTH(4), .X_W(XW)) u_sync (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_x_i(s_in_x), .in_tag_i(s_in_tag),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_x_o(s_out_x), .out_tag_o(s_out_tag),
        .eng_start_o(s_start), .eng_x_o(s_eng_xo), .eng_x_i(s_eng_xi), .eng_done_i(s_done),
        .eng_sync_i(s_sync), .outstanding_o(s_outst), .err_o(s_err)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [XW-1:0] x;
        logic [TW-1:0] tag;
        int            due;
    } job_t;

    typedef struct {
        logic [XW-1:0] x;
        logic [TW-1:0] tag;
    } res_t;

    job_t          inflight[$];   // accepted jobs, issue order
    res_t          fifo_q[$];     // results waiting at the output
    int            slot_due[N];   // cycle at which each slot becomes free
    bit            m_err;

    // behavioural engine
    int            eng_due[N];
    logic [XW-1:0] eng_res[N];
    logic [N-1:0]  inj_done;

    bit full_chk;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int n_acc   = 0;
    int last_issue  = -1;
    int first_valid = -1;

    function automatic logic [XW-1:0] eng_f(input logic [XW-1:0] x);
        return (x * 32'd5) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", name, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check 1 time unit later, then
    // advance the model to what the next rising edge should produce.
    task automatic step(input bit v, input logic [XW-1:0] x, input logic [TW-1:0] tg, input bit ordy);
        int           es;
        bit           exp_ready;
        logic [N-1:0] exp_start;
        @(negedge clk);
        eng_done = inj_done;
        for (int k = 0; k < N; k++) begin
            if (eng_due[k] == cyc) begin
                eng_done[k] = 1'b1;
                eng_xi[k]   = eng_res[k];
            end
        end
        in_valid  = v;
        in_x      = x;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        es = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (slot_due[k] <= cyc) es = k;
        end
        exp_ready = (es >= 0) && ((inflight.size() + fifo_q.size()) < DEPTH);
        exp_start = (v && exp_ready) ? (N'(1) << es) : '0;
        if (full_chk) begin
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("eng_start", 64'(eng_start), 64'(exp_start));
            check("eng_x", 64'(eng_xo[N-1]), 64'(x));
            check("outstanding", 64'(outstanding), 64'(inflight.size()));
            check("out_valid", 64'(out_valid), 64'(fifo_q.size() > 0));
            if (fifo_q.size() > 0) begin
                check("out_tag", 64'(out_tag), 64'(fifo_q[0].tag));
                check("out_x", 64'(out_x), 64'(fifo_q[0].x));
            end
        end
        check("err", 64'(err), 64'(m_err));
        if (out_valid && first_valid < 0) first_valid = cyc;

        for (int k = 0; k < N; k++) begin
            if (eng_start[k]) begin
                eng_due[k] = cyc + LAT;
                eng_res[k] = eng_f(eng_xo[k]);
            end
        end
        if (v && in_ready) begin
            n_acc      = n_acc + 1;
            last_issue = cyc;
        end

        if (ordy && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            fifo_q.push_back(res_t'{eng_f(inflight[0].x), inflight[0].tag});
            void'(inflight.pop_front());
        end
        if (v && exp_ready) begin
            slot_due[es] = cyc + LAT;
            inflight.push_back(job_t'{x, tg, cyc + LAT});
        end
        if (inj_done != '0) m_err = 1'b1;
    endtask

    task automatic idle(input int cycles, input bit ordy);
        for (int i = 0; i < cycles; i++) step(1'b0, 32'($urandom), 8'h00, ordy);
    endtask

    // Hold one operand until it is accepted, bounded.
    task automatic send(input logic [XW-1:0] x, input logic [TW-1:0] tg, input bit ordy);
        int a0;
        int i;
        a0 = n_acc;
        i  = 0;
        while (n_acc == a0 && i < 400) begin
            step(1'b1, x, tg, ordy);
            i++;
        end
        if (n_acc == a0) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        s_in_valid = 1'b0;
        inj_done   = '0;
        eng_done   = '0;
        inflight.delete();
        fifo_q.delete();
        for (int k = 0; k < N; k++) begin
            slot_due[k] = -1;
            eng_due[k]  = -1000;
        end
        m_err    = 1'b0;
        full_chk = 1'b1;
        @(negedge clk);
        #1;
        check("rst_start", 64'(eng_start), 64'(0));
        check("rst_outstanding", 64'(outstanding), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int sn;
        logic [2:0] s_exp;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        eng_xi      = '0;
        eng_done    = '0;
        eng_sync    = 1'b1;
        inj_done    = '0;
        s_in_valid  = 1'b0;
        s_in_x      = 32'h0000_00AB;
        s_in_tag    = 8'h00;
        s_out_ready = 1'b0;
        s_eng_xi    = '0;
        s_done      = '0;
        s_sync      = 1'b1;

        do_reset();

        // single job: tag 0x11, x=5, result 259 cycles later
        idle(3, 1'b1);
        first_valid = -1;
        send(32'h5, 8'h11, 1'b1);
        check("single_start_slot", 64'(last_issue >= 0), 64'(1));
        for (int i = 0; i < 300 && first_valid < 0; i++) idle(1, 1'b1);
        check("single_latency", 64'(first_valid - last_issue), 64'(259));
        idle(3, 1'b1);

        // slot exhaustion: six back-to-back operands, in-order results
        for (int i = 0; i < 6; i++) send(32'($urandom), 8'(8'h20 + i), 1'b1);
        idle(280, 1'b1);
        check("exhaust_drained", 64'(inflight.size() + fifo_q.size()), 64'(0));

        // credit backpressure: consumer stalled, only DEPTH jobs fit
        a0 = n_acc;
        for (int i = 0; i < 600; i++) step(1'b1, 32'($urandom), 8'(8'h40 + i), 1'b0);
        check("credit_accepted", 64'(n_acc - a0), 64'(DEPTH));
        idle(1, 1'b1);
        step(1'b1, 32'h0BAD_F00D, 8'h77, 1'b0);
        check("credit_reopen", 64'(n_acc - a0), 64'(DEPTH + 1));
        idle(300, 1'b1);

        // error: done on an idle slot is sticky until reset
        do_reset();
        idle(3, 1'b1);
        full_chk = 1'b0;
        inj_done = 4'b0100;
        idle(1, 1'b1);
        inj_done = '0;
        idle(5, 1'b1);
        do_reset();
        idle(2, 1'b1);

        // reset mid-operation, then a fresh job with normal latency
        for (int i = 0; i < 3; i++) send(32'($urandom), 8'(8'h60 + i), 1'b1);
        idle(50, 1'b1);
        do_reset();
        idle(2, 1'b1);
        first_valid = -1;
        send(32'h1234_5678, 8'h99, 1'b1);
        for (int i = 0; i < 300 && first_valid < 0; i++) idle(1, 1'b1);
        check("post_reset_latency", 64'(first_valid - last_issue), 64'(259));
        idle(3, 1'b1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0), 32'($urandom), 8'($urandom),
                 ($urandom_range(0, 2) != 0));
        end
        idle(300, 1'b1);
        check("random_drained", 64'(inflight.size() + fifo_q.size()), 64'(0));

        // sync-mode instance: issue only on sync cycles
        do_reset();
        sn = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s_sync     = (i % 3 == 0);
            s_in_valid = 1'b1;
            s_in_x     = 32'($urandom);
            #1;
            s_exp = (s_sync && sn < 3) ? (3'b001 << sn) : 3'b000;
            check("sync_ready", 64'(s_in_ready), 64'(s_sync && sn < 3));
            check("sync_start", 64'(s_start), 64'(s_exp));
            check("sync_eng_x", 64'(s_eng_xo[2]), 64'(s_in_x));
            if (s_exp != 3'b000) sn++;
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        s_sync     = 1'b1;
        #1;
        check("sync_outstanding", 64'(s_outst), 64'(3));
        check("sync_err", 64'(s_err), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/penta_root_dispatch.md
# penta_root_dispatch

Job dispatcher and result collector placed directly upstream and downstream of the N-slot MinRoot 5th-root engine. It accepts a single valid/ready stream of tagged `poly_t` operands. Each operand goes to a free engine slot via a one-cycle start pulse. The block tracks slot occupancy, captures each slot's result on its done pulse and returns results with their tags through a credit-protected output FIFO. The engine therefore never produces a result that has nowhere to go.

## Interface
- `N`, 1: number of engine slots; must match the engine instance.
- `SYNC`, 0: 1 when the engine is built with SYNC=1. Starts are then legal only when `eng_sync_i`=1.
- `TAG_W`, 8: job tag width.
- `OUT_DEPTH`, 4: result FIFO depth; must be ≥1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `in_valid_i`  in  1  operand valid.
- `in_ready_o`  out  1  operand accepted when `in_valid_i` & `in_ready_o`.
- `in_x_i`  in  poly_t  operand.
- `in_tag_i`  in  TAG_W  operand tag.
- `out_valid_o`  out  1  result valid (FIFO non-empty).
- `out_ready_i`  in  1  result consumed when `out_valid_o` & `out_ready_i`.
- `out_x_o`  out  poly_t  result (FIFO head).
- `out_tag_o`  out  TAG_W  tag of the head result.
- `eng_start_o`  out  N  per-slot start pulse to the engine; at most one bit set.
- `eng_x_o`  out  N×poly_t  per-slot operand to the engine; every element carries `in_x_i`.
- `eng_x_i`  in  N×poly_t  per-slot result from the engine.
- `eng_done_i`  in  N  per-slot done from the engine.
- `eng_sync_i`  in  1  engine sync indication.
- `outstanding_o`  out  $clog2(N+1)  number of busy slots.
- `err_o`  out  1  sticky protocol error.

## Operation
- **Per-slot state:** a `busy` bit and a `tag` register.
- **Free-slot selection:** `free` = !busy | eng_done_i, so a slot completing this cycle may be restarted this same cycle. The lowest-index free slot is selected.
- **Credit:**
  - `credit_ok` = (outstanding + fifo_count) < OUT_DEPTH.
  - A FIFO pop in the current cycle does not add credit until the next cycle.
  - A done in the current cycle does not change the sum, because the job moves from outstanding to FIFO.
- **Ready:** `in_ready_o` = any free slot & credit_ok & (!SYNC | eng_sync_i). The logic is combinational and does not depend on `in_valid_i`.
- **Issue** (accept):
  - `eng_start_o[k]`=1 for the selected slot in the same cycle.
  - busy[k] is set and tag[k] is loaded with `in_tag_i` at the clock edge.
  - At most one issue per cycle.
- **Completion** (eng_done_i[k]=1):
  - Push {eng_x_i[k], tag[k]} into the FIFO.
  - Clear busy[k], unless slot k is re-issued in the same cycle, in which case busy stays 1 and tag[k] is replaced.
- **Result ordering:** the engine latency is fixed and issue is at most one per cycle, so at most one done occurs per cycle. Results therefore leave in issue order.
- **FIFO:** circular buffer with OUT_DEPTH entries.
  - Push and pop in the same cycle are both performed; the count is unchanged.
  - Pop when empty is ignored.
  - Credit guarantees that a push never finds the FIFO full.
- **`err_o`** is set, and stays set until reset, on any of:
  - more than one `eng_done_i` bit in a cycle;
  - done on a non-busy slot;
  - a push when the FIFO is full. The data is dropped, the FIFO is unchanged, and the error is still flagged.
- **Reset** (any time, including mid-job):
  - all busy bits cleared, FIFO emptied, err cleared.
  - in-flight engine results are lost. The engine shares `rst_ni`, so it is reset too.

## Timing
- **Reset values:**
  - `eng_start_o`=0, `out_valid_o`=0, `outstanding_o`=0, `err_o`=0.
  - `in_ready_o`=1 once out of reset with SYNC=0; with SYNC=1 it equals `eng_sync_i`. The engine resets sync to 1.
- **Engine latency:** `eng_done_i[k]` asserts exactly 258 cycles after `eng_start_o[k]`.
- **End-to-end latency:** an operand accepted in cycle t produces `out_valid_o` in cycle t+259, provided the FIFO was empty. The extra cycle is the FIFO register.
- **Output path:** `out_valid_o`, `out_x_o` and `out_tag_o` are registered (FIFO state) and do not depend combinationally on `out_ready_i`.
- **Throughput:**
  - 1 job/cycle with SYNC=0, limited by min(N, OUT_DEPTH) outstanding.
  - With SYNC=1, at most one job per sync cycle (every N cycles).

## Test plan
- **Single job:** N=4, SYNC=0, x=0x5 with tag 0x11 accepted at cycle 10 → `eng_start_o`=4'b0001 at cycle 10; `outstanding_o`=1 until done; `out_valid_o` at cycle 269 with tag 0x11 and the engine's result; `err_o`=0.
- **Slot exhaustion:** N=4, OUT_DEPTH=8, 6 back-to-back operands → slots 0,1,2,3 start on consecutive cycles; `in_ready_o`=0 until the slot-0 done cycle; slot 0 is restarted in that done cycle; results leave with tags in issue order.
- **Credit backpressure:** N=4, OUT_DEPTH=2, `out_ready_i`=0 → only 2 jobs are accepted and `in_ready_o` stays 0. Raising `out_ready_i` for one cycle → `in_ready_o` returns to 1 the following cycle; the FIFO never overflows.
- **SYNC mode:** SYNC=1, N=3, `in_valid_i` held high → issues occur only in cycles with `eng_sync_i`=1, i.e. every 3rd cycle.
- **Error detection:** inject `eng_done_i`=4'b0100 while slot 2 is idle → `err_o`=1 on the next cycle and stays 1; asserting `rst_ni` low clears it.
- **Reset mid-operation:** 3 jobs outstanding, pulse `rst_ni` → `outstanding_o`=0, `out_valid_o`=0, and a fresh job completes normally with 259-cycle latency.
